// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Hardwired fetch/decode/execute sequencer for the Bus datapath. It drives
//   every bus-drive select, register load, ALU operation, PC and memory strobe
//   that the datapath consumes. It reads back the IR opcode and the CON flag.
//
//   State is registered. Every output is decoded combinationally from the
//   current state and ir[31:27]. The only other inputs that reach the outputs
//   are con, in the branch T6 step, and clr through the async reset.
//
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   ir         IR contents: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//   con        branch condition from the datapath CON logic
//   mem_rdy    memory access completes this cycle
//   stop       request a halt at the next instruction boundary
//   PCout..Rout           bus-drive selects
//   PCins..Rin            register load strobes
//   Gra/Grb/Grc           IR register-field select for Rin/Rout/BAOut
//   incPC, MDRRead, mem_write
//   ALUop      ALU operation select
//   run        high while sequencing instructions
//
// State    | meaning
// ---------+--------------------------------------------------------------
// RESET    | held in reset; leaves on the first edge with clr high
// T0       | PC -> MAR, PC increment
// T1       | memory -> MDR; waits here for mem_rdy
// T2       | MDR -> IR
// T3..T7   | execute steps selected by ir[31:27]
// HALT     | stopped; run low, no strobes; left only through clr
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int                 OPW     = 5,
  parameter int                 DATA_W  = 32,
  parameter logic [OPW-1:0]     ALU_ADD = 5'b00011
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] ir,
  input  logic              con,
  input  logic              mem_rdy,
  input  logic              stop,

  output logic              PCout,
  output logic              ZLOout,
  output logic              ZHIout,
  output logic              MDRout,
  output logic              Cout,
  output logic              BAOut,
  output logic              Rout,

  output logic              PCins,
  output logic              MARins,
  output logic              MDRins,
  output logic              IRins,
  output logic              Yin,
  output logic              ZLOins,
  output logic              ZHIins,
  output logic              CONins,
  output logic              Rin,

  output logic              Gra,
  output logic              Grb,
  output logic              Grc,

  output logic              incPC,
  output logic              MDRRead,
  output logic              mem_write,

  output logic [OPW-1:0]    ALUop,
  output logic              run
);

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t boundary_state;

  logic [OPW-1:0] op;
  logic           is_rtype;
  logic           is_addi;
  logic           is_ld;
  logic           is_st;
  logic           is_br;
  logic           is_halt;
  logic           is_mem;

  // Only the opcode field steers the sequencer; the register fields are
  // consumed by the datapath's select logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[DATA_W-OPW-1:0];

  assign op = ir[DATA_W-1 -: OPW];

  always_comb begin
    is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    is_addi  = (op == OP_ADDI);
    is_ld    = (op == OP_LD);
    is_st    = (op == OP_ST);
    is_br    = (op == OP_BR);
    is_halt  = (op == OP_HALT);
    is_mem   = is_ld || is_st;
  end

  // stop is only honoured at an instruction boundary, so every path that
  // would enter T0 goes through this single decision.
  assign boundary_state = stop ? ST_HALT : ST_T0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = boundary_state;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = mem_rdy ? ST_T2 : ST_T1;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        if (is_rtype || is_addi || is_mem || is_br) begin
          state_d = ST_T4;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = boundary_state;
        end
      end
      ST_T4: begin
        if (is_rtype || is_addi || is_mem || is_br) begin
          state_d = ST_T5;
        end else begin
          state_d = boundary_state;
        end
      end
      ST_T5: begin
        if (is_mem || is_br) begin
          state_d = ST_T6;
        end else begin
          state_d = boundary_state;
        end
      end
      ST_T6: begin
        if (is_ld) begin
          state_d = mem_rdy ? ST_T7 : ST_T6;
        end else if (is_st) begin
          state_d = ST_T7;
        end else begin
          state_d = boundary_state;
        end
      end
      ST_T7: begin
        // Only a store waits on memory in T7; a load already has its data.
        if (is_st && !mem_rdy) begin
          state_d = ST_T7;
        end else begin
          state_d = boundary_state;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
  end

  // Output decode
  always_comb begin
    PCout     = 1'b0;
    ZLOout    = 1'b0;
    ZHIout    = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    BAOut     = 1'b0;
    Rout      = 1'b0;
    PCins     = 1'b0;
    MARins    = 1'b0;
    MDRins    = 1'b0;
    IRins     = 1'b0;
    Yin       = 1'b0;
    ZLOins    = 1'b0;
    ZHIins    = 1'b0;
    CONins    = 1'b0;
    Rin       = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    incPC     = 1'b0;
    MDRRead   = 1'b0;
    mem_write = 1'b0;
    ALUop     = '0;
    run       = 1'b0;

    case (state_q)
      ST_T0: begin
        run    = 1'b1;
        PCout  = 1'b1;
        MARins = 1'b1;
        incPC  = 1'b1;
      end
      ST_T1: begin
        run     = 1'b1;
        MDRRead = 1'b1;
        MDRins  = 1'b1;
      end
      ST_T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRins  = 1'b1;
      end
      ST_T3: begin
        run = 1'b1;
        if (is_rtype || is_addi) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_mem) begin
          // Base register via BAOut so that R0 reads as zero for absolute addressing.
          Grb   = 1'b1;
          BAOut = 1'b1;
          Yin   = 1'b1;
        end else if (is_br) begin
          Gra    = 1'b1;
          Rout   = 1'b1;
          CONins = 1'b1;
        end
      end
      ST_T4: begin
        run = 1'b1;
        if (is_rtype) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          ALUop  = op;
          ZLOins = 1'b1;
          ZHIins = 1'b1;
        end else if (is_addi || is_mem) begin
          Cout   = 1'b1;
          ALUop  = ALU_ADD;
          ZLOins = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
      end
      ST_T5: begin
        run = 1'b1;
        if (is_rtype || is_addi) begin
          ZLOout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_mem) begin
          ZLOout = 1'b1;
          MARins = 1'b1;
        end else if (is_br) begin
          Cout   = 1'b1;
          ALUop  = ALU_ADD;
          ZLOins = 1'b1;
        end
      end
      ST_T6: begin
        run = 1'b1;
        if (is_ld) begin
          MDRRead = 1'b1;
          MDRins  = 1'b1;
        end else if (is_st) begin
          // MDRRead low selects the bus into MDR rather than memory.
          Gra    = 1'b1;
          Rout   = 1'b1;
          MDRins = 1'b1;
        end else if (is_br && con) begin
          ZLOout = 1'b1;
          PCins  = 1'b1;
        end
      end
      ST_T7: begin
        run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_st) begin
          mem_write = 1'b1;
        end
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

endmodule
